// File: rtl/instr_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of a single-cycle core.
// Hits are served combinationally; misses stall the core while a req/ack fetch fills the line.
module instr_fetch_cache #(
    parameter int          LINES = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        Stall,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [15:0] HitCount,
    output logic [15:0] MissCount
);
    // state   | meaning
    // S_IDLE  | lookup PC every cycle; hit serves, miss launches a fetch
    // S_FETCH | request outstanding, waiting for MemAck to fill the line
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             discard_q, discard_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;

    logic [IDXW-1:0] pc_idx;
    logic [TAGW-1:0] pc_tag;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] fill_tag;
    logic            hit;
    logic            ack;
    logic            start_fetch;
    logic            fill_we;

    assign pc_idx   = PC[IDXW+1:2];
    assign pc_tag   = PC[31:IDXW+2];
    assign fill_idx = mem_addr_q[IDXW+1:2];
    assign fill_tag = mem_addr_q[31:IDXW+2];

    assign hit = (state_q == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !Flush;
    assign ack = (state_q == S_FETCH) && mem_req_q && MemAck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!hit && !Flush) state_d = S_FETCH;
            S_FETCH: if (ack)            state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of array contents.
    always_comb begin
        Instruction = NOP;
        Stall       = rst_n;
        start_fetch = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    Instruction = data_q[pc_idx];
                    Stall       = 1'b0;
                end else if (!Flush) begin
                    start_fetch = 1'b1;
                end
            end
            S_FETCH: begin
                fill_we = ack && !discard_q && !Flush;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;

        if (start_fetch) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {PC[31:2], 2'b00};
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end

        if (state_q == S_FETCH) begin
            if (ack) begin
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end else if (Flush) begin
                discard_d = 1'b1;
            end
        end

        // Flush beats a same-cycle fill so a stale word can never become valid.
        if (Flush) begin
            valid_d = '0;
        end else if (fill_we) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            discard_q  <= 1'b0;
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag/data need no reset: nothing reads them unless the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= MemRData;
        end
    end

    assign MemReq    = mem_req_q;
    assign MemAddr   = mem_addr_q;
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;

endmodule
